// File: rtl/alt_times_1pt8_arb_pkg.sv
// Shared constants for the round-robin multiply-by-461/256 arbiter and its multiplier.
// Holds FIFO depth, multiplier latency, stat counter width and the id-width helper.
package alt_times_1pt8_arb_pkg;

  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned MulLat      = 2;
  localparam int unsigned StatW       = 16;
  localparam int unsigned MulConst    = 461;
  localparam int unsigned MulFracBits = 8;
  localparam int unsigned OccW        = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW        = $clog2(FifoDepth);

  typedef logic [StatW-1:0] stat_cnt_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alt_times_1pt8.sv
// Two-stage pipelined multiply by 461/256: operand register, then truncated scaled product.
// The product wraps at WIDTH+8 bits before the shift; no rounding or saturation.
module alt_times_1pt8
  import alt_times_1pt8_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int unsigned ProdW = WIDTH + MulFracBits;

  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_dout;
  logic [ProdW-1:0] w_prod;

  // Product is computed in ProdW bits, so the top bits wrap away by construction.
  assign w_prod = ProdW'(r_din) * ProdW'(MulConst);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_din  <= '0;
      r_dout <= '0;
    end else begin
      r_din  <= i_din;
      r_dout <= WIDTH'(w_prod >> MulFracBits);
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/alt_times_1pt8_arb.sv
// Round-robin arbiter sharing one multiply-by-461/256 unit, with tag pipe, credited output FIFO.
// Define ALT_TIMES_1PT8_ARB_STATS_EN to enable saturating per-requester grant counters.
module alt_times_1pt8_arb
  import alt_times_1pt8_arb_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdW     = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IdW-1:0]           res_id,
  output logic [WIDTH-1:0]         res_data,
  output logic [NUM_REQ*StatW-1:0] stat_grants
);

  logic [IdW-1:0]   r_ptr;
  logic [MulLat-1:0] r_v;
  logic [IdW-1:0]   r_id [MulLat];

  logic [PtrW-1:0]  r_wr;
  logic [PtrW-1:0]  r_rd;
  logic [OccW-1:0]  r_occ;
  logic [WIDTH-1:0] r_mem_data [FifoDepth];
  logic [IdW-1:0]   r_mem_id   [FifoDepth];

  logic             w_any;
  logic [IdW-1:0]   w_gnt_idx;
  logic [IdW:0]     w_scan;
  logic [IdW-1:0]   w_ptr_nxt;
  logic [OccW-1:0]  w_used;
  logic             w_credit_ok;
  logic             w_issue;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_mul_out;
  logic             w_push;
  logic             w_pop;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IdW+1)'(k);
      if (w_scan >= (IdW+1)'(NUM_REQ)) begin
        w_scan = w_scan - (IdW+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[w_scan[IdW-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_scan[IdW-1:0];
      end
    end
  end

  // Occupancy plus in-flight; a pop this cycle is deliberately not treated as a credit.
  always_comb begin
    w_used = r_occ;
    for (int s = 0; s < MulLat; s++) begin
      w_used = w_used + OccW'(r_v[s]);
    end
  end

  assign w_credit_ok = (w_used < OccW'(FifoDepth));
  assign w_issue     = w_any && w_credit_ok && !arst;
  assign w_ptr_nxt   = (w_gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IdW'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_issue && (w_gnt_idx == IdW'(i));
    end
  end

  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IdW'(i)) begin
        w_din = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  alt_times_1pt8 #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk    (clk),
    .arst   (arst),
    .i_din  (w_din),
    .o_dout (w_mul_out)
  );

  assign w_push = r_v[MulLat-1];
  assign w_pop  = res_valid && res_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr <= '0;
      r_v   <= '0;
      for (int s = 0; s < MulLat; s++) begin
        r_id[s] <= '0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= w_ptr_nxt;
      end
      r_v     <= {r_v[MulLat-2:0], w_issue};
      r_id[0] <= w_gnt_idx;
      for (int s = 1; s < MulLat; s++) begin
        r_id[s] <= r_id[s-1];
      end
      if (w_push) begin
        r_wr <= r_wr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PtrW'(1);
      end
      r_occ <= r_occ + OccW'(w_push) - OccW'(w_pop);
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= w_mul_out;
      r_mem_id[r_wr]   <= r_id[MulLat-1];
    end
  end

  assign res_valid = (r_occ != '0);
  assign res_id    = res_valid ? r_mem_id[r_rd]   : '0;
  assign res_data  = res_valid ? r_mem_data[r_rd] : '0;

`ifdef ALT_TIMES_1PT8_ARB_STATS_EN
  stat_cnt_t r_stat [NUM_REQ];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_stat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (r_stat[i] != '1)) begin
          r_stat[i] <= r_stat[i] + StatW'(1);
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*StatW +: StatW] = r_stat[i];
    end
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alt_times_1pt8_arb.sv
// Self-checking bench for alt_times_1pt8_arb: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alt_times_1pt8_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [W-1:0]    res_data;
  logic [N*16-1:0] stat_grants;

  alt_times_1pt8_arb #(
    .WIDTH   (W),
    .NUM_REQ (N)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_data    (res_data),
    .stat_grants (stat_grants)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int data;
    int due;
  } ent_t;

  typedef struct {
    int         id;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  ent_t m_pend[$];
  ent_t m_fifo[$];
  int   m_ptr;
  int   cyc;
  int   m_grants[N];
  int   dut_gid;
  int   obs_ids[$];
  int   obs_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_mul(input int d);
    return ((d * 461) % 65536) / 256;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_fifo.delete();
    m_ptr = 0;
    cyc   = 0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
  endtask

  // Called once per cycle at the falling edge, after inputs have settled.
  task automatic cycle_check();
    int credits;
    int gid;
    logic [N-1:0] exp_rdy;
    while (m_pend.size() > 0 && m_pend[0].due <= cyc) m_fifo.push_back(m_pend.pop_front());
    credits = 4 - m_fifo.size() - m_pend.size();
    gid = -1;
    if (credits > 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    exp_rdy = '0;
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    dut_gid = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_gid = i;
    check("req_ready", req_ready, exp_rdy);
    check("res_valid", res_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      check("res_id", res_id, m_fifo[0].id);
      check("res_data", res_data, m_fifo[0].data);
    end
    if (res_valid && res_ready) begin
      obs_ids.push_back(int'(res_id));
      obs_data.push_back(int'(res_data));
    end
    if (gid >= 0) begin
      m_pend.push_back('{gid, ref_mul(int'(req_data[gid*W +: W])), cyc + 3});
      m_ptr = (gid + 1) % N;
      if (m_grants[gid] < 65535) m_grants[gid]++;
    end
    if (m_fifo.size() != 0 && res_ready) void'(m_fifo.pop_front());
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic check_stats(input string name);
    for (int i = 0; i < N; i++) begin
`ifdef ALT_TIMES_1PT8_ARB_STATS_EN
      check(name, stat_grants[i*16 +: 16], m_grants[i]);
`else
      check(name, stat_grants[i*16 +: 16], 0);
`endif
    end
  endtask

  vec_t tbl[8];
  int   acc;
  int   drv[$];
  logic [7:0] d1;

  initial begin
    tbl[0] = '{0, 8'd100, 8'd180};
    tbl[1] = '{1, 8'd0,   8'd0};
    tbl[2] = '{2, 8'd10,  8'd18};
    tbl[3] = '{3, 8'd255, 8'd203};
    tbl[4] = '{1, 8'd128, 8'd230};
    tbl[5] = '{2, 8'd200, 8'd104};
    tbl[6] = '{0, 8'd1,   8'd1};
    tbl[7] = '{3, 8'd50,  8'd90};

    // Reset: outputs must be quiet even with every requester asking.
    arst      = 1'b1;
    req_valid = '1;
    req_data  = $urandom;
    res_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_data", res_data, 0);
    check("rst_stats", stat_grants, 0);
    arst      = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    model_reset();

    // Table: single request, result exactly three cycles after acceptance.
    for (int t = 0; t < 8; t++) begin
      req_data = $urandom;
      req_data[tbl[t].id*W +: W] = tbl[t].din;
      req_valid = 4'b0001 << tbl[t].id;
      @(negedge clk);
      check("tbl_ready", req_ready, 4'b0001 << tbl[t].id);
      cycle_check();
      @(posedge clk);
      #1;
      req_valid = '0;
      step();
      step();
      @(negedge clk);
      check("tbl_valid", res_valid, 1);
      check("tbl_id", res_id, tbl[t].id);
      check("tbl_data", res_data, tbl[t].exp);
      cycle_check();
      @(posedge clk);
      #1;
    end
    check_stats("stats_tbl");

    // Fairness: all valid, consumer always ready.
    obs_ids.delete();
    obs_data.delete();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      req_data = $urandom;
      @(negedge clk);
      cycle_check();
      check("fair_grant", dut_gid, k % 4);
      @(posedge clk);
      #1;
    end
    drain();
    check("fair_count", obs_ids.size(), 12);
    for (int j = 0; j < obs_ids.size(); j++) check("fair_order", obs_ids[j], j % 4);

    // Backpressure: consumer stalled, requester 2 always valid.
    obs_ids.delete();
    obs_data.delete();
    drv.delete();
    acc = 0;
    res_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      req_data = $urandom;
      @(negedge clk);
      if (req_ready[2]) begin
        acc++;
        drv.push_back(int'(req_data[23:16]));
      end
      cycle_check();
      @(posedge clk);
      #1;
    end
    check("bp_accepts", acc, 4);
    @(negedge clk);
    check("bp_stall", req_ready, 0);
    cycle_check();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_data = $urandom;
      @(negedge clk);
      if (req_ready[2]) begin
        acc++;
        drv.push_back(int'(req_data[23:16]));
      end
      cycle_check();
      @(posedge clk);
      #1;
    end
    check("bp_resume", acc > 4, 1);
    drain();
    check("bp_no_loss", obs_data.size(), acc);
    for (int j = 0; j < obs_data.size() && j < drv.size(); j++) begin
      check("bp_data", obs_data[j], ref_mul(drv[j]));
    end
    check_stats("stats_bp");

    // Reset mid-flight: queued and in-flight results must all disappear.
    res_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (4) begin
      req_data = $urandom;
      step();
    end
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    obs_ids.delete();
    obs_data.delete();
    check_stats("stats_rst");
    req_valid = 4'b0010;
    req_data  = $urandom;
    d1        = req_data[15:8];
    res_ready = 1'b1;
    @(negedge clk);
    check("first_accept", req_ready, 4'b0010);
    cycle_check();
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (8) step();
    check("no_stale_count", obs_ids.size(), 1);
    if (obs_ids.size() > 0) begin
      check("no_stale_id", obs_ids[0], 1);
      check("no_stale_data", obs_data[0], ref_mul(int'(d1)));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    check_stats("stats_rand");

`ifdef ALT_TIMES_1PT8_ARB_STATS_EN
    // Saturation of requester 1's counter.
    req_valid = 4'b0010;
    res_ready = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      req_data = $urandom;
      step();
    end
    drain();
    check("stats_sat", stat_grants[31:16], 16'hFFFF);
    check_stats("stats_final");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
